// File: rtl/ysyx_23060203_div_unit_if.sv
// Handshake bundle between the EXU and the multi-cycle divider:
// an operand channel (in_*) and a result channel (out_*).
interface ysyx_23060203_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_ready;
    logic             in_valid;
    logic             in_sign;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_quot;
    logic [WIDTH-1:0] out_rem;

    // Requester side: issues operands, consumes results.
    modport master (
        input  in_ready,
        input  out_valid,
        input  out_quot,
        input  out_rem,
        output in_valid,
        output in_sign,
        output in_a,
        output in_b,
        output out_ready
    );

    // Divider side.
    modport slave (
        output in_ready,
        output out_valid,
        output out_quot,
        output out_rem,
        input  in_valid,
        input  in_sign,
        input  in_a,
        input  in_b,
        input  out_ready
    );
endinterface

// File: rtl/ysyx_23060203_div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU.
// Special cases (divide by zero, signed overflow) resolve in one cycle;
// everything else runs WIDTH/STEPS CALC cycles on magnitudes and fixes
// the signs of quotient and remainder on the last CALC cycle.
module ysyx_23060203_div_unit #(
    parameter int WIDTH = 32,
    parameter int STEPS = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic flush,
    ysyx_23060203_div_unit_if.slave io
);

    localparam int ITER  = WIDTH / STEPS;
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Iteration state: partial remainder, dividend that gradually turns into
    // the quotient (quotient bits shift in at the LSB), divisor magnitude.
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] div_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;

    // Registered results, held stable through DONE.
    logic [WIDTH-1:0] quot_out_reg;
    logic [WIDTH-1:0] rem_out_reg;

    // Operand decode in IDLE.
    logic             accept;
    logic             b_zero;
    logic             sign_ovf;
    logic             special;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    assign accept   = (state_reg == S_IDLE) && io.in_valid && !flush;
    assign b_zero   = (io.in_b == '0);
    assign sign_ovf = io.in_sign && (io.in_a == MIN_NEG) && (io.in_b == '1);
    assign special  = b_zero || sign_ovf;
    assign a_neg    = io.in_sign && io.in_a[WIDTH-1];
    assign b_neg    = io.in_sign && io.in_b[WIDTH-1];
    // The most negative value maps onto itself, which read as unsigned is
    // exactly its magnitude, so no extra bit is needed.
    assign abs_a    = a_neg ? (~io.in_a + WIDTH'(1)) : io.in_a;
    assign abs_b    = b_neg ? (~io.in_b + WIDTH'(1)) : io.in_b;

    // STEPS chained restoring iterations per CALC cycle.
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] dvd_step;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // Combinational iteration chain for one CALC cycle.
    always_comb begin
        rem_step = rem_reg;
        dvd_step = dvd_reg;
        shifted  = '0;
        diff     = '0;
        for (int i = 0; i < STEPS; i++) begin
            shifted  = {rem_step, dvd_step[WIDTH-1]};
            diff     = shifted - {1'b0, div_reg};
            // A borrow out of the WIDTH+1-bit subtraction means the trial
            // failed: keep the shifted value (restore) and shift in a 0.
            rem_step = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            dvd_step = {dvd_step[WIDTH-2:0], ~diff[WIDTH]};
        end
    end

    // Sign fix-up of the final magnitudes (two's complement, mod 2^WIDTH).
    logic [WIDTH-1:0] quot_res;
    logic [WIDTH-1:0] rem_res;

    // Apply quotient/remainder sign on the last CALC cycle.
    always_comb begin
        quot_res = neg_q_reg ? (~dvd_step + WIDTH'(1)) : dvd_step;
        rem_res  = neg_r_reg ? (~rem_step + WIDTH'(1)) : rem_step;
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (io.in_valid) begin
                        state_next = special ? S_DONE : S_CALC;
                    end
                end
                S_CALC: begin
                    if (cnt_reg == '0) begin
                        state_next = S_DONE;
                    end
                end
                S_DONE: begin
                    if (io.out_ready) begin
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Handshake outputs decoded from state; results come from registers.
    always_comb begin
        io.in_ready  = (state_reg == S_IDLE);
        io.out_valid = (state_reg == S_DONE);
        io.out_quot  = quot_out_reg;
        io.out_rem   = rem_out_reg;
    end

    // Datapath: operand latch on accept, iteration in CALC, result capture.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rem_reg      <= '0;
            dvd_reg      <= '0;
            div_reg      <= '0;
            cnt_reg      <= '0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            quot_out_reg <= '0;
            rem_out_reg  <= '0;
        end else if (!flush) begin
            if (accept) begin
                if (b_zero) begin
                    quot_out_reg <= '1;
                    rem_out_reg  <= io.in_a;
                end else if (sign_ovf) begin
                    quot_out_reg <= io.in_a;
                    rem_out_reg  <= '0;
                end else begin
                    rem_reg   <= '0;
                    dvd_reg   <= abs_a;
                    div_reg   <= abs_b;
                    neg_q_reg <= a_neg ^ b_neg;
                    neg_r_reg <= a_neg;
                    cnt_reg   <= CNT_LAST;
                end
            end else if (state_reg == S_CALC) begin
                rem_reg <= rem_step;
                dvd_reg <= dvd_step;
                cnt_reg <= cnt_reg - CNT_W'(1);
                if (cnt_reg == '0) begin
                    quot_out_reg <= quot_res;
                    rem_out_reg  <= rem_res;
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_23060203_div_unit.sv
// Directed and randomised checks of the divider with STEPS=1 and STEPS=4.
module tb_ysyx_23060203_div_unit;

    logic clock  = 1'b0;
    logic rst_n  = 1'b0;
    logic flush1 = 1'b0;
    logic flush4 = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    ysyx_23060203_div_unit_if #(.WIDTH(32)) bus1 ();
    ysyx_23060203_div_unit_if #(.WIDTH(32)) bus4 ();

    ysyx_23060203_div_unit #(.WIDTH(32), .STEPS(1)) dut1 (
        .clock (clock),
        .reset (rst_n),
        .flush (flush1),
        .io    (bus1)
    );

    ysyx_23060203_div_unit #(.WIDTH(32), .STEPS(4)) dut4 (
        .clock (clock),
        .reset (rst_n),
        .flush (flush4),
        .io    (bus4)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic s,
                         input logic [31:0] a, input logic [31:0] b);
        if (sel == 1) begin
            bus1.in_valid = v; bus1.in_sign = s; bus1.in_a = a; bus1.in_b = b;
        end else begin
            bus4.in_valid = v; bus4.in_sign = s; bus4.in_a = a; bus4.in_b = b;
        end
    endtask

    task automatic set_ready(input int sel, input logic r);
        if (sel == 1) bus1.out_ready = r;
        else          bus4.out_ready = r;
    endtask

    function automatic logic get_valid(input int sel);
        return (sel == 1) ? bus1.out_valid : bus4.out_valid;
    endfunction

    function automatic logic get_in_ready(input int sel);
        return (sel == 1) ? bus1.in_ready : bus4.in_ready;
    endfunction

    // Starts at a negedge; returns at the negedge of the first cycle with
    // out_valid high (or when the cycle budget runs out). cyc counts cycles
    // after the accept edge.
    task automatic run_op(input int sel, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic rdy,
                          output logic [31:0] q, output logic [31:0] r,
                          output int cyc, output logic vld);
        set_ready(sel, rdy);
        drive(sel, 1'b1, s, a, b);
        @(negedge clock);
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
        cyc = 1;
        while (get_valid(sel) !== 1'b1 && cyc < 60) begin
            @(negedge clock);
            cyc++;
        end
        vld = get_valid(sel);
        q = (sel == 1) ? bus1.out_quot : bus4.out_quot;
        r = (sel == 1) ? bus1.out_rem  : bus4.out_rem;
    endtask

    // Full transaction with out_ready high; also checks the return to IDLE.
    task automatic do_op(input string tag, input int sel, input logic s,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input int ecyc);
        logic [31:0] q, r;
        int cyc;
        logic vld;
        run_op(sel, s, a, b, 1'b1, q, r, cyc, vld);
        $display("[TB] %s dut%0d s=%0d a=%08h b=%08h -> q=%08h r=%08h cyc=%0d",
                 tag, sel, s, a, b, q, r, cyc);
        check({tag, ".valid"}, 32'(vld), 32'd1);
        check({tag, ".quot"}, q, eq);
        check({tag, ".rem"}, r, er);
        check({tag, ".cyc"}, 32'(cyc), 32'(ecyc));
        @(negedge clock);
        check({tag, ".in_ready_after"}, 32'(get_in_ready(sel)), 32'd1);
        check({tag, ".valid_after"}, 32'(get_valid(sel)), 32'd0);
    endtask

    task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic spec);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        spec = 1'b0;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; spec = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = 32'd0; spec = 1'b1;
        end else if (s) begin
            q = sa / sb; r = sa % sb;
        end else begin
            q = a / b; r = a % b;
        end
    endtask

    task automatic rand_op(input int sel, input int idx);
        logic [31:0] a, b, eq, er;
        logic s, spec;
        int k;
        s = 1'($urandom_range(0, 1));
        a = $urandom;
        k = $urandom_range(0, 9);
        if (k == 0)      b = 32'd0;
        else if (k <= 3) b = $urandom_range(1, 20);
        else if (k == 4) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        else if (k == 5) b = 32'hFFFF_FFFF - $urandom_range(0, 5);
        else             b = $urandom;
        model(s, a, b, eq, er, spec);
        do_op($sformatf("rnd%0d", idx), sel, s, a, b, eq, er,
              spec ? 1 : ((sel == 1) ? 33 : 9));
    endtask

    initial begin
        logic [31:0] q, r;
        int cyc, seen;
        logic vld;

        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(4, 1'b0, 1'b0, 32'd0, 32'd0);
        set_ready(1, 1'b1);
        set_ready(4, 1'b1);

        // Reset state.
        repeat (3) @(negedge clock);
        check("rst.in_ready", 32'(bus1.in_ready), 32'd1);
        check("rst.out_valid", 32'(bus1.out_valid), 32'd0);
        check("rst.quot", bus1.out_quot, 32'd0);
        check("rst.rem", bus1.out_rem, 32'd0);
        check("rst4.in_ready", 32'(bus4.in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clock);

        // Basic unsigned / signed, STEPS=1.
        do_op("u100_7", 1, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        do_op("s-7_2", 1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        do_op("s7_-2", 1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);

        // Special cases.
        do_op("s5_0", 1, 1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1);
        do_op("u5_0", 1, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1);
        do_op("s_ovf", 1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1);
        do_op("u_ovf", 1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);

        // STEPS=4.
        do_op("q4_u", 4, 1'b0, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 32'd0, 9);
        do_op("q4_s", 4, 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 9);
        do_op("q4_0", 4, 1'b0, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 1);

        // Flush in cycle 10 of CALC.
        drive(1, 1'b1, 1'b0, 32'd1000, 32'd3);
        @(negedge clock);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (9) @(negedge clock);
        flush1 = 1'b1;
        @(negedge clock);
        flush1 = 1'b0;
        check("flush.in_ready", 32'(bus1.in_ready), 32'd1);
        check("flush.out_valid", 32'(bus1.out_valid), 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus1.out_valid === 1'b1) seen++;
        end
        check("flush.no_valid", 32'(seen), 32'd0);
        $display("[TB] flush dut1 a=000003e8 b=00000003 aborted, valid_seen=%0d", seen);
        do_op("post_flush", 1, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);

        // Backpressure: out_ready low for 5 cycles in DONE.
        run_op(4, 1'b0, 32'd1000, 32'd33, 1'b0, q, r, cyc, vld);
        $display("[TB] bp dut4 a=000003e8 b=00000021 -> q=%08h r=%08h cyc=%0d", q, r, cyc);
        check("bp.quot", q, 32'd30);
        check("bp.rem", r, 32'd10);
        check("bp.cyc", 32'(cyc), 32'd9);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("bp.hold_valid", 32'(bus4.out_valid), 32'd1);
            check("bp.hold_quot", bus4.out_quot, 32'd30);
            check("bp.hold_rem", bus4.out_rem, 32'd10);
            check("bp.hold_in_ready", 32'(bus4.in_ready), 32'd0);
        end
        bus4.out_ready = 1'b1;
        @(negedge clock);
        check("bp.released_valid", 32'(bus4.out_valid), 32'd0);
        check("bp.released_in_ready", 32'(bus4.in_ready), 32'd1);

        // Reset asserted mid-DONE acts without a clock edge.
        run_op(1, 1'b0, 32'd100, 32'd7, 1'b0, q, r, cyc, vld);
        check("rd.quot_before", q, 32'd14);
        #2;
        rst_n = 1'b0;
        #1;
        check("rd.out_valid", 32'(bus1.out_valid), 32'd0);
        check("rd.quot", bus1.out_quot, 32'd0);
        check("rd.rem", bus1.out_rem, 32'd0);
        check("rd.in_ready", 32'(bus1.in_ready), 32'd1);
        $display("[TB] reset mid-DONE dut1 valid=%0d q=%08h", bus1.out_valid, bus1.out_quot);
        @(negedge clock);
        bus1.out_ready = 1'b1;
        rst_n = 1'b1;
        @(negedge clock);

        // Reset asserted mid-CALC, then a clean restart.
        drive(1, 1'b1, 1'b0, 32'd1000, 32'd3);
        @(negedge clock);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (5) @(negedge clock);
        check("rc.in_ready_busy", 32'(bus1.in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rc.out_valid", 32'(bus1.out_valid), 32'd0);
        check("rc.in_ready", 32'(bus1.in_ready), 32'd1);
        $display("[TB] reset mid-CALC dut1 valid=%0d in_ready=%0d", bus1.out_valid, bus1.in_ready);
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        do_op("post_reset", 1, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);

        // Random regression against the reference model.
        for (int i = 0; i < 200; i++) rand_op(4, i);
        for (int i = 0; i < 20; i++) rand_op(1, 200 + i);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
